// File: rtl/serial_to_parallel_rx.sv
// Receive-side deserializer: aligns an MSB-first serial stream on comma symbols
// and delivers strobed parallel bytes, flagging only payload bytes as valid.
module serial_to_parallel_rx #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter logic [7:0]  IDLE_SYM    = 8'h7C,
  parameter int unsigned COMMA_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic       active,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe
);

  // state     | meaning
  // ----------+--------------------------------------------------------
  // ST_SEARCH | bit-by-bit hunt for a comma, bitcnt held at 0
  // ST_ALIGN  | counting consecutive commas on the candidate boundary
  // ST_ACTIVE | locked, deliver every byte; left only through reset
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] COMMA_CNT_L = 4'(COMMA_COUNT);

  state_t      state, state_nxt;
  logic [6:0]  shreg;
  logic [2:0]  bitcnt, bitcnt_nxt;
  logic [3:0]  commacnt, commacnt_nxt;
  logic [7:0]  nxt;
  logic        boundary;
  logic        active_nxt;
  logic [7:0]  data_out_nxt;
  logic        valid_nxt;
  logic        strobe_nxt;

  // Only the low seven bits of the shifted byte are ever needed again.
  assign nxt      = {shreg, data_in};
  assign boundary = (bitcnt == 3'd7);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state       <= ST_SEARCH;
      shreg       <= 7'd0;
      bitcnt      <= 3'd0;
      commacnt    <= 4'd0;
      active      <= 1'b0;
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= nxt[6:0];
      bitcnt      <= bitcnt_nxt;
      commacnt    <= commacnt_nxt;
      active      <= active_nxt;
      data_out    <= data_out_nxt;
      valid_out   <= valid_nxt;
      byte_strobe <= strobe_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bitcnt_nxt   = bitcnt;
    commacnt_nxt = commacnt;
    active_nxt   = active;
    data_out_nxt = data_out;
    valid_nxt    = 1'b0;
    strobe_nxt   = 1'b0;
    case (state)
      ST_SEARCH: begin
        bitcnt_nxt = 3'd0;
        if (nxt == COMMA) begin
          commacnt_nxt = 4'd1;
          if (COMMA_CNT_L == 4'd1) begin
            state_nxt  = ST_ACTIVE;
            active_nxt = 1'b1;
          end else begin
            state_nxt = ST_ALIGN;
          end
        end
      end
      ST_ALIGN: begin
        bitcnt_nxt = bitcnt + 3'd1;
        if (boundary) begin
          if (nxt == COMMA) begin
            if ((commacnt + 4'd1) >= COMMA_CNT_L) begin
              commacnt_nxt = COMMA_CNT_L;
              state_nxt    = ST_ACTIVE;
              active_nxt   = 1'b1;
            end else begin
              commacnt_nxt = commacnt + 4'd1;
            end
          end else begin
            // A broken run drops straight back; this byte is not re-hunted.
            commacnt_nxt = 4'd0;
            state_nxt    = ST_SEARCH;
          end
        end
      end
      ST_ACTIVE: begin
        bitcnt_nxt = bitcnt + 3'd1;
        if (boundary) begin
          data_out_nxt = nxt;
          strobe_nxt   = 1'b1;
          valid_nxt    = (nxt != COMMA) && (nxt != IDLE_SYM);
        end
      end
      default: begin
        state_nxt = ST_SEARCH;
      end
    endcase
  end

endmodule
